// File: rtl/micro_tile_pkg.sv
// Shared types and constants for the micro-tile select path.
package micro_tile_pkg;

    localparam int NUM_TILES = 4;
    localparam int SEL_W     = 2;

    typedef enum logic [2:0] {
        RUN,
        DRAIN,
        GATE,
        SWITCH,
        WAKE
    } state_t;

    function automatic logic [NUM_TILES-1:0] onehot4(input logic [SEL_W-1:0] idx);
        logic [NUM_TILES-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/micro_sel_debounce.sv
// Synchronises the raw select pins and raises req once a new select has held steady.
// Optional MICRO_TILE_SEL_LOCK_EN adds a synchronised sel_lock that suppresses req.
module micro_sel_debounce
    import micro_tile_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] sel_in,
`ifdef MICRO_TILE_SEL_LOCK_EN
    input  logic             sel_lock,
`endif
    input  logic [SEL_W-1:0] sel,
    output logic [SEL_W-1:0] candidate,
    output logic             req
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [SEL_W-1:0] sync_q1;
    logic [SEL_W-1:0] sel_sync;
    logic [CNT_W-1:0] stable_cnt;
    logic             lock_block;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1    <= '0;
            sel_sync   <= '0;
            candidate  <= '0;
            stable_cnt <= '0;
        end else begin
            sync_q1   <= sel_in;
            sel_sync  <= sync_q1;
            candidate <= sel_sync;
            if (sel_sync != candidate) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

`ifdef MICRO_TILE_SEL_LOCK_EN
    logic lock_q1;
    logic lock_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q1   <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_q1   <= sel_lock;
            lock_sync <= lock_q1;
        end
    end

    assign lock_block = lock_sync;
`else
    assign lock_block = 1'b0;
`endif

    // The counter saturates, so a still-stable candidate re-requests once the FSM is back in RUN.
    assign req = (stable_cnt == CNT_MAX) && (candidate != sel) && !lock_block;

endmodule

// File: rtl/micro_tile_selector.sv
// Debounced tile select with a drain / gate / switch / wake sequence per tile change.
// Optional MICRO_TILE_SEL_LOCK_EN adds the sel_lock input that holds the current tile.
module micro_tile_selector
    import micro_tile_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int RESET_CYCLES  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SEL_W-1:0]     sel_in,
`ifdef MICRO_TILE_SEL_LOCK_EN
    input  logic                 sel_lock,
`endif
    output logic [SEL_W-1:0]     sel,
    output logic [NUM_TILES-1:0] tile_clk_en,
    output logic [NUM_TILES-1:0] tile_rst_n,
    output logic                 busy
);

    localparam int RCNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RESET_CYCLES - 1);

    state_t               state;
    state_t               state_d;
    logic [RCNT_W-1:0]    rst_cnt;
    logic [RCNT_W-1:0]    rst_cnt_d;
    logic [SEL_W-1:0]     target;
    logic [SEL_W-1:0]     target_d;
    logic [SEL_W-1:0]     sel_d;
    logic [NUM_TILES-1:0] clk_en_d;
    logic [NUM_TILES-1:0] tile_rst_q;
    logic [NUM_TILES-1:0] tile_rst_d;
    logic                 busy_d;
    logic [SEL_W-1:0]     candidate;
    logic                 req;

    micro_sel_debounce #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel_in   (sel_in),
`ifdef MICRO_TILE_SEL_LOCK_EN
        .sel_lock (sel_lock),
`endif
        .sel      (sel),
        .candidate(candidate),
        .req      (req)
    );

    // Tile-facing outputs are flopped from the next-state decode so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAKE;
            rst_cnt     <= '0;
            sel         <= '0;
            target      <= '0;
            tile_clk_en <= NUM_TILES'(1);
            tile_rst_q  <= '0;
            busy        <= 1'b1;
        end else begin
            state       <= state_d;
            rst_cnt     <= rst_cnt_d;
            sel         <= sel_d;
            target      <= target_d;
            tile_clk_en <= clk_en_d;
            tile_rst_q  <= tile_rst_d;
            busy        <= busy_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state;
        rst_cnt_d = rst_cnt;
        target_d  = target;
        sel_d     = sel;
        unique case (state)
            RUN: begin
                if (req) begin
                    state_d   = DRAIN;
                    target_d  = candidate;
                    rst_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (rst_cnt == RCNT_LAST) begin
                    state_d   = GATE;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt + 1'b1;
                end
            end
            GATE: begin
                state_d = SWITCH;
            end
            SWITCH: begin
                sel_d     = target;
                state_d   = WAKE;
                rst_cnt_d = '0;
            end
            WAKE: begin
                if (rst_cnt == RCNT_LAST) begin
                    state_d   = RUN;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt + 1'b1;
                end
            end
            default: begin
                state_d   = WAKE;
                rst_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        clk_en_d   = onehot4(sel_d);
        tile_rst_d = '0;
        busy_d     = 1'b1;
        unique case (state_d)
            RUN: begin
                tile_rst_d = onehot4(sel_d);
                busy_d     = 1'b0;
            end
            GATE, SWITCH: begin
                clk_en_d = '0;
            end
            default: begin
            end
        endcase
    end

    assign tile_rst_n = tile_rst_q & {NUM_TILES{rst_n}};

endmodule

// File: tb/tb_micro_tile_selector.sv
// Directed and randomized bench for micro_tile_selector against a timeline reference model.
module tb_micro_tile_selector;

    localparam int SC = 4;
    localparam int RC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sel_in = 2'd0;
`ifdef MICRO_TILE_SEL_LOCK_EN
    logic       sel_lock = 1'b0;
`endif
    logic [1:0] sel;
    logic [3:0] tile_clk_en;
    logic [3:0] tile_rst_n;
    logic       busy;

    micro_tile_selector #(
        .STABLE_CYCLES(SC),
        .RESET_CYCLES (RC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_in     (sel_in),
`ifdef MICRO_TILE_SEL_LOCK_EN
        .sel_lock   (sel_lock),
`endif
        .sel        (sel),
        .tile_clk_en(tile_clk_en),
        .tile_rst_n (tile_rst_n),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pin/lock history per clock edge plus a position in the switch timeline.
    // m_step < 0 means RUN; 0..RC-1 drain, RC gate, RC+1 switch, RC+2..2*RC+1 wake.
    int hist[$];
    int lhist[$];
    int m_sel;
    int m_step;
    int m_target;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lock_now();
`ifdef MICRO_TILE_SEL_LOCK_EN
        return int'(sel_lock);
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        hist.delete();
        lhist.delete();
        repeat (SC + 2) begin
            hist.push_back(0);
            lhist.push_back(0);
        end
        m_sel    = 0;
        m_step   = RC + 2;
        m_target = 0;
    endtask

    // Called at each rising edge with the pin values being sampled on that edge.
    task automatic model_edge(input int pin, input int lock);
        int n;
        int cand;
        bit stable;
        bit req;
        n      = hist.size();
        cand   = hist[n-3];
        stable = 1'b1;
        for (int k = 3; k <= SC + 2; k++) begin
            if (hist[n-k] != cand) stable = 1'b0;
        end
        req = (m_step < 0) && stable && (cand != m_sel) && (lhist[n-2] == 0);
        if (m_step < 0) begin
            if (req) begin
                m_step   = 0;
                m_target = cand;
            end
        end else begin
            if (m_step == RC + 1) m_sel = m_target;
            m_step++;
            if (m_step == 2 * RC + 2) m_step = -1;
        end
        hist.push_back(pin);
        lhist.push_back(lock);
        while (hist.size() > 16) begin
            void'(hist.pop_front());
            void'(lhist.pop_front());
        end
    endtask

    task automatic compare_all(input string tag);
        logic [3:0] oh;
        logic [3:0] exp_en;
        logic [3:0] exp_rst;
        logic       exp_busy;
        oh = 4'(1 << m_sel);
        if (m_step < 0) begin
            exp_en   = oh;
            exp_rst  = oh;
            exp_busy = 1'b0;
        end else if (m_step == RC || m_step == RC + 1) begin
            exp_en   = 4'b0000;
            exp_rst  = 4'b0000;
            exp_busy = 1'b1;
        end else begin
            exp_en   = oh;
            exp_rst  = 4'b0000;
            exp_busy = 1'b1;
        end
        check($sformatf("%s_sel", tag), 32'(sel), 32'(m_sel));
        check($sformatf("%s_clk_en", tag), 32'(tile_clk_en), 32'(exp_en));
        check($sformatf("%s_rst_n", tag), 32'(tile_rst_n), 32'(exp_rst));
        check($sformatf("%s_busy", tag), 32'(busy), 32'(exp_busy));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge(int'(sel_in), lock_now());
        @(negedge clk);
        compare_all(tag);
    endtask

    // Entered and left at a falling edge.
    task automatic do_async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(posedge clk);
        @(negedge clk);
        compare_all("rst_held");
        rst_n = 1'b1;
    endtask

    initial begin
        bit found;

        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all("reset");
        rst_n = 1'b1;

        step("wake0");
        check("wake0_rst_n", 32'(tile_rst_n), 32'h0);
        step("wake1");
        check("run_rst_n", 32'(tile_rst_n), 32'h1);
        check("run_busy", 32'(busy), 32'h0);

        // Short flicker that never reaches the stability window.
        sel_in = 2'd1;
        repeat (3) step("pulse");
        sel_in = 2'd0;
        repeat (10) step("pulse_idle");
        check("pulse_sel", 32'(sel), 32'h0);

        // 0 -> 2: req appears six edges after the pin change, DRAIN on the seventh.
        sel_in = 2'd2;
        repeat (6) step("sw2_wait");
        check("sw2_pre_busy", 32'(busy), 32'h0);
        step("sw2_drain");
        check("sw2_drain_busy", 32'(busy), 32'h1);
        check("sw2_drain_clk_en", 32'(tile_clk_en), 32'h1);
        repeat (7) step("sw2_seq");
        check("sw2_sel", 32'(sel), 32'h2);
        check("sw2_rst_n", 32'(tile_rst_n), 32'h4);

        sel_in = 2'd0;
        repeat (16) step("back0");
        check("back0_sel", 32'(sel), 32'h0);

        // Pin moves to 3 while the switch to 2 is in flight.
        sel_in = 2'd2;
        repeat (9) step("mid_a");
        sel_in = 2'd3;
        repeat (30) step("mid_b");
        check("mid_sel", 32'(sel), 32'h3);

        sel_in = 2'd0;
        repeat (16) step("back0b");

        // Reset asserted while the 0 -> 1 switch has its clocks gated.
        sel_in = 2'd1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step("to_gate");
            if (busy === 1'b1 && tile_clk_en === 4'b0000) found = 1'b1;
        end
        check("gate_reached", 32'(found), 32'h1);
        sel_in = 2'd0;
        do_async_reset();
        repeat (14) step("post_rst");
        check("post_rst_sel", 32'(sel), 32'h0);

`ifdef MICRO_TILE_SEL_LOCK_EN
        sel_lock = 1'b1;
        sel_in   = 2'd3;
        repeat (20) step("locked");
        check("locked_sel", 32'(sel), 32'h0);
        check("locked_busy", 32'(busy), 32'h0);
        sel_lock = 1'b0;
        repeat (3) step("unlock");
        check("unlock_busy", 32'(busy), 32'h1);
        repeat (20) step("unlock_done");
        check("unlock_sel", 32'(sel), 32'h3);
`endif

        repeat (150) begin
            int len;
            sel_in = 2'($urandom_range(0, 3));
`ifdef MICRO_TILE_SEL_LOCK_EN
            sel_lock = ($urandom_range(0, 7) == 0);
`endif
            if ($urandom_range(0, 24) == 0) begin
                do_async_reset();
            end
            len = $urandom_range(1, 12);
            repeat (len) step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
